// File: rtl/battle_box_if.sv
// rtl/battle_box_if.sv - target request/response bundle for the battle box
interface battle_box_if #(
    parameter int CW = 10
);
    logic [CW-1:0] tgt_x0;
    logic [CW-1:0] tgt_y0;
    logic [CW-1:0] tgt_x1;
    logic [CW-1:0] tgt_y1;
    logic          tgt_valid;
    logic          tgt_ready;
    logic          tgt_err;
    logic          done;

    modport master (
        output tgt_x0, tgt_y0, tgt_x1, tgt_y1, tgt_valid,
        input  tgt_ready, tgt_err, done
    );

    modport slave (
        input  tgt_x0, tgt_y0, tgt_x1, tgt_y1, tgt_valid,
        output tgt_ready, tgt_err, done
    );
endinterface

// File: rtl/battle_box.sv
// rtl/battle_box.sv - animated play-area box with border/interior pixel masks
module battle_box #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int CW      = 10,
    parameter int BORDER  = 4,
    parameter int STEP    = 4,
    parameter int INIT_X0 = 32,
    parameter int INIT_Y0 = 240,
    parameter int INIT_X1 = 607,
    parameter int INIT_Y1 = 447
) (
    input  logic          Pclk,
    input  logic          rst_n,
    input  logic [CW-1:0] xx,
    input  logic [CW-1:0] yy,
    input  logic          aactive,
    input  logic          frame_tick,
    battle_box_if.slave   tgt,
    output logic [CW-1:0] box_x0,
    output logic [CW-1:0] box_y0,
    output logic [CW-1:0] box_x1,
    output logic [CW-1:0] box_y1,
    output logic          box_on,
    output logic          border_on,
    output logic          inner_on
);
    localparam logic [CW:0] STEP_W    = (CW+1)'(STEP);
    localparam logic [CW:0] BORDER_W  = (CW+1)'(BORDER);
    localparam logic [CW:0] BORDER2_W = (CW+1)'(2 * BORDER);
    localparam logic [CW:0] XMAX_W    = (CW+1)'(H_RES - 1);
    localparam logic [CW:0] YMAX_W    = (CW+1)'(V_RES - 1);

    typedef enum logic [0:0] {IDLE, MOVE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] t_x0, t_y0, t_x1, t_y1;
    logic [CW-1:0] n_x0, n_y0, n_x1, n_y1;
    logic          latch, move_en, err_nxt, done_nxt, tgt_ok;
    logic          tgt_err_q, done_q;

    // Move one edge toward its target, clamped to STEP; widened so the distance never wraps.
    function automatic logic [CW-1:0] approach(input logic [CW-1:0] cur, input logic [CW-1:0] tg);
        logic [CW:0] c;
        logic [CW:0] t;
        logic [CW:0] d;
        c = {1'b0, cur};
        t = {1'b0, tg};
        if (t > c) begin
            d = t - c;
            if (d > STEP_W) d = STEP_W;
            approach = CW'(c + d);
        end else begin
            d = c - t;
            if (d > STEP_W) d = STEP_W;
            approach = CW'(c - d);
        end
    endfunction

    assign tgt_ok = ({1'b0, tgt.tgt_x1} <= XMAX_W) &&
                    ({1'b0, tgt.tgt_y1} <= YMAX_W) &&
                    ({1'b0, tgt.tgt_x1} >= {1'b0, tgt.tgt_x0} + BORDER2_W) &&
                    ({1'b0, tgt.tgt_y1} >= {1'b0, tgt.tgt_y0} + BORDER2_W);

    assign n_x0 = approach(box_x0, t_x0);
    assign n_y0 = approach(box_y0, t_y0);
    assign n_x1 = approach(box_x1, t_x1);
    assign n_y1 = approach(box_y1, t_y1);

    assign tgt.tgt_ready = (state == IDLE);
    assign tgt.tgt_err   = tgt_err_q;
    assign tgt.done      = done_q;

    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        move_en   = 1'b0;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (tgt.tgt_valid) begin
                    if (tgt_ok) begin
                        latch     = 1'b1;
                        state_nxt = MOVE;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            MOVE: begin
                if (frame_tick) begin
                    move_en = 1'b1;
                    if (n_x0 == t_x0 && n_y0 == t_y0 && n_x1 == t_x1 && n_y1 == t_y1) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            t_x0      <= CW'(INIT_X0);
            t_y0      <= CW'(INIT_Y0);
            t_x1      <= CW'(INIT_X1);
            t_y1      <= CW'(INIT_Y1);
            box_x0    <= CW'(INIT_X0);
            box_y0    <= CW'(INIT_Y0);
            box_x1    <= CW'(INIT_X1);
            box_y1    <= CW'(INIT_Y1);
            tgt_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tgt_err_q <= err_nxt;
            done_q    <= done_nxt;
            if (latch) begin
                t_x0 <= tgt.tgt_x0;
                t_y0 <= tgt.tgt_y0;
                t_x1 <= tgt.tgt_x1;
                t_y1 <= tgt.tgt_y1;
            end
            // Corners only change on the blanking tick so a frame is never torn.
            if (move_en) begin
                box_x0 <= n_x0;
                box_y0 <= n_y0;
                box_x1 <= n_x1;
                box_y1 <= n_y1;
            end
        end
    end

    logic [CW:0] xw, yw;
    logic        in_box, in_inner;

    assign xw = {1'b0, xx};
    assign yw = {1'b0, yy};

    assign in_box = aactive &&
                    (xw >= {1'b0, box_x0}) && (xw <= {1'b0, box_x1}) &&
                    (yw >= {1'b0, box_y0}) && (yw <= {1'b0, box_y1});

    // Right/bottom inset compares with the offset on the scan side to avoid subtracting from the corner.
    assign in_inner = (xw >= {1'b0, box_x0} + BORDER_W) && (xw + BORDER_W <= {1'b0, box_x1}) &&
                      (yw >= {1'b0, box_y0} + BORDER_W) && (yw + BORDER_W <= {1'b0, box_y1});

    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            box_on    <= 1'b0;
            border_on <= 1'b0;
            inner_on  <= 1'b0;
        end else begin
            box_on    <= in_box;
            inner_on  <= in_box && in_inner;
            border_on <= in_box && !in_inner;
        end
    end
endmodule

// File: tb/tb_battle_box.sv
// tb/tb_battle_box.sv - directed vector bench for battle_box
module tb_battle_box;
    logic       Pclk = 1'b0;
    logic       rst_n;
    logic [9:0] xx, yy;
    logic       aactive, frame_tick;
    logic [9:0] box_x0, box_y0, box_x1, box_y1;
    logic       box_on, border_on, inner_on;
    int         checks = 0;
    int         errors = 0;

    battle_box_if #(.CW(10)) bif ();

    battle_box #(
        .H_RES(640), .V_RES(480), .CW(10), .BORDER(4), .STEP(4),
        .INIT_X0(32), .INIT_Y0(240), .INIT_X1(607), .INIT_Y1(447)
    ) dut (
        .Pclk(Pclk), .rst_n(rst_n), .xx(xx), .yy(yy), .aactive(aactive),
        .frame_tick(frame_tick), .tgt(bif),
        .box_x0(box_x0), .box_y0(box_y0), .box_x1(box_x1), .box_y1(box_y1),
        .box_on(box_on), .border_on(border_on), .inner_on(inner_on)
    );

    always #20 Pclk = ~Pclk;

    typedef struct {
        int x;
        int y;
        int act;
        int e_box;
        int e_border;
        int e_inner;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_box(input string nm, input int x0, input int y0, input int x1, input int y1);
        chk({nm, "_x0"}, int'(box_x0), x0);
        chk({nm, "_y0"}, int'(box_y0), y0);
        chk({nm, "_x1"}, int'(box_x1), x1);
        chk({nm, "_y1"}, int'(box_y1), y1);
    endtask

    task automatic tick();
        repeat (3) @(negedge Pclk);
        frame_tick = 1'b1;
        @(posedge Pclk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic offer(input int x0, input int y0, input int x1, input int y1, input logic with_tick);
        @(negedge Pclk);
        bif.tgt_x0    = 10'(x0);
        bif.tgt_y0    = 10'(y0);
        bif.tgt_x1    = 10'(x1);
        bif.tgt_y1    = 10'(y1);
        bif.tgt_valid = 1'b1;
        frame_tick    = with_tick;
        @(posedge Pclk);
        #1;
        bif.tgt_valid = 1'b0;
        frame_tick    = 1'b0;
    endtask

    initial begin
        int done_at;

        vecs[0] = '{32, 240, 1, 1, 1, 0};
        vecs[1] = '{36, 244, 1, 1, 0, 1};
        vecs[2] = '{31, 240, 1, 0, 0, 0};
        vecs[3] = '{607, 447, 1, 1, 1, 0};
        vecs[4] = '{603, 443, 1, 1, 0, 1};
        vecs[5] = '{604, 300, 1, 1, 1, 0};
        vecs[6] = '{608, 300, 1, 0, 0, 0};
        vecs[7] = '{100, 448, 1, 0, 0, 0};
        vecs[8] = '{36, 244, 0, 0, 0, 0};
        vecs[9] = '{32, 240, 0, 0, 0, 0};

        rst_n = 1'b0;
        xx = '0; yy = '0; aactive = 1'b0; frame_tick = 1'b0;
        bif.tgt_x0 = '0; bif.tgt_y0 = '0; bif.tgt_x1 = '0; bif.tgt_y1 = '0;
        bif.tgt_valid = 1'b0;
        repeat (3) @(posedge Pclk);
        #1;
        chk("rst_ready", int'(bif.tgt_ready), 1);
        chk("rst_err", int'(bif.tgt_err), 0);
        chk("rst_done", int'(bif.done), 0);
        chk("rst_box_on", int'(box_on), 0);
        chk("rst_border_on", int'(border_on), 0);
        chk("rst_inner_on", int'(inner_on), 0);
        chk_box("rst", 32, 240, 607, 447);
        @(negedge Pclk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge Pclk);
            xx      = 10'(vecs[i].x);
            yy      = 10'(vecs[i].y);
            aactive = vecs[i].act[0];
            @(posedge Pclk);
            #1;
            chk($sformatf("box_on[%0d]", i), int'(box_on), vecs[i].e_box);
            chk($sformatf("border_on[%0d]", i), int'(border_on), vecs[i].e_border);
            chk($sformatf("inner_on[%0d]", i), int'(inner_on), vecs[i].e_inner);
        end
        aactive = 1'b0;

        offer(100, 140, 105, 339, 1'b0);
        chk("narrow_err", int'(bif.tgt_err), 1);
        chk("narrow_ready", int'(bif.tgt_ready), 1);
        chk_box("narrow", 32, 240, 607, 447);
        @(posedge Pclk);
        #1;
        chk("narrow_err_pulse", int'(bif.tgt_err), 0);
        offer(0, 0, 640, 100, 1'b0);
        chk("xrange_err", int'(bif.tgt_err), 1);
        offer(0, 400, 100, 407, 1'b0);
        chk("short_err", int'(bif.tgt_err), 1);
        offer(0, 100, 100, 480, 1'b0);
        chk("yrange_err", int'(bif.tgt_err), 1);

        offer(32, 240, 607, 447, 1'b0);
        chk("same_ready", int'(bif.tgt_ready), 0);
        chk("same_err", int'(bif.tgt_err), 0);
        offer(100, 140, 105, 339, 1'b0);
        chk("ignored_err", int'(bif.tgt_err), 0);
        chk("ignored_ready", int'(bif.tgt_ready), 0);
        chk("same_no_done", int'(bif.done), 0);
        tick();
        chk("same_done", int'(bif.done), 1);
        chk("same_ready_back", int'(bif.tgt_ready), 1);
        chk_box("same", 32, 240, 607, 447);
        @(posedge Pclk);
        #1;
        chk("same_done_pulse", int'(bif.done), 0);

        offer(232, 140, 407, 339, 1'b0);
        chk("move_ready", int'(bif.tgt_ready), 0);
        done_at = -1;
        for (int i = 1; i <= 60 && done_at < 0; i++) begin
            tick();
            chk($sformatf("width_t%0d", i), (int'(box_x1) - int'(box_x0) >= 175) ? 1 : 0, 1);
            if (bif.done) begin
                done_at = i;
                chk("move_ready_at_done", int'(bif.tgt_ready), 1);
            end
        end
        chk("move_ticks", done_at, 50);
        chk_box("move", 232, 140, 407, 339);
        @(posedge Pclk);
        #1;
        chk("move_done_pulse", int'(bif.done), 0);

        offer(200, 140, 407, 339, 1'b1);
        chk("coinc_ready", int'(bif.tgt_ready), 0);
        chk("coinc_hold_x0", int'(box_x0), 232);
        done_at = -1;
        for (int i = 1; i <= 20 && done_at < 0; i++) begin
            tick();
            if (i == 1) chk("coinc_first_x0", int'(box_x0), 228);
            if (bif.done) done_at = i;
        end
        chk("coinc_ticks", done_at, 8);
        chk_box("coinc", 200, 140, 407, 339);

        offer(0, 0, 639, 479, 1'b0);
        tick();
        tick();
        chk_box("pre_rst", 192, 132, 415, 347);
        @(negedge Pclk);
        #7;
        rst_n = 1'b0;
        #1;
        chk_box("async_rst", 32, 240, 607, 447);
        chk("async_ready", int'(bif.tgt_ready), 1);
        @(negedge Pclk);
        rst_n = 1'b1;
        tick();
        chk_box("post_rst", 32, 240, 607, 447);
        chk("post_rst_done", int'(bif.done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
